bcd_display_feeder: RTL and testbench

Sequential binary-to-BCD front end for the 4-digit seven-segment path. It accepts a 14-bit unsigned binary value on a start strobe and converts it to four packed BCD digits with an iterative shift-add-3 (double-dabble) datapath. It drives the `hexs`, `points` and `LEs` inputs of the number-display stage directly. Outputs are registered and held stable between conversions, so the display scanner always sees a coherent 4-digit word.

---
 rtl/bcd_display_feeder.sv | 119 +++++++++++
 tb/tb_bcd_display_feeder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_feeder.sv
// rtl/bcd_display_feeder.sv - sequential binary-to-BCD converter feeding the 4-digit seven-segment stage
`timescale 1ns/1ps
module bcd_display_feeder #(
    parameter int WIDTH         = 14,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    input  logic [3:0]       dp_sel,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [15:0]      hexs,
    output logic [3:0]       points,
    output logic [3:0]       LEs
);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    localparam logic [3:0] LES_RESET  = BLANK_LEADING ? 4'b1110 : 4'b0000;
    localparam logic [3:0] LAST_SHIFT = 4'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [15+WIDTH:0]  sreg;
    logic [3:0]         cnt;
    logic [3:0]         dp_latched;
    logic               ovf_latched;
    logic               accept;
    logic               shifting;
    logic               loading;
    logic [15:0]        bcd_adj;
    logic [15:0]        bcd_res;
    logic [3:0]         les_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST_SHIFT) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        accept   = (state == IDLE) && start;
        shifting = (state == SHIFT);
        loading  = (state == LOAD);
    end

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 4; i++) begin
            if (sreg[WIDTH + 4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = sreg[WIDTH + 4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = sreg[WIDTH + 4*i +: 4];
            end
        end
    end

    always_comb begin
        bcd_res = sreg[WIDTH +: 16];
        les_res = 4'b0000;
        if (ovf_latched) begin
            bcd_res = 16'hEEEE;
        end else if (BLANK_LEADING) begin
            les_res[3] = (bcd_res[15:12] == 4'd0);
            les_res[2] = les_res[3] && (bcd_res[11:8] == 4'd0);
            les_res[1] = les_res[2] && (bcd_res[7:4] == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg        <= '0;
            cnt         <= '0;
            dp_latched  <= '0;
            ovf_latched <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            hexs        <= 16'h0000;
            points      <= 4'b0000;
            LEs         <= LES_RESET;
        end else begin
            done <= loading;
            if (accept) begin
                sreg        <= {16'h0000, bin};
                cnt         <= '0;
                dp_latched  <= dp_sel;
                ovf_latched <= (32'(bin) > 32'd9999);
            end else if (shifting) begin
                sreg <= {bcd_adj, sreg[WIDTH-1:0]} << 1;
                cnt  <= cnt + 4'd1;
            end
            // Result registers move together so the scanner never sees a mixed word.
            if (loading) begin
                hexs     <= bcd_res;
                LEs      <= les_res;
                points   <= dp_latched;
                overflow <= ovf_latched;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_feeder.sv
// tb/tb_bcd_display_feeder.sv - randomized self-checking bench for bcd_display_feeder
`timescale 1ns/1ps
module tb_bcd_display_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic [3:0]  dp_sel;
    logic        busy, done, overflow;
    logic [15:0] hexs;
    logic [3:0]  points, les;
    logic        busy_nb, done_nb, overflow_nb;
    logic [15:0] hexs_nb;
    logic [3:0]  points_nb, les_nb;

    int n_checks = 0;
    int n_pass   = 0;
    int done_at, done_cnt, busy_cnt, early_change;
    int both_high = 0;

    always #5 clk = ~clk;

    bcd_display_feeder #(.WIDTH(14), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .dp_sel(dp_sel),
        .busy(busy), .done(done), .overflow(overflow), .hexs(hexs),
        .points(points), .LEs(les)
    );

    bcd_display_feeder #(.WIDTH(14), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .dp_sel(dp_sel),
        .busy(busy_nb), .done(done_nb), .overflow(overflow_nb), .hexs(hexs_nb),
        .points(points_nb), .LEs(les_nb)
    );

    always @(negedge clk) if (busy && done) both_high++;

    function automatic logic [15:0] model_hexs(input int v);
        if (v > 9999) return 16'hEEEE;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] model_les(input int v);
        if (v > 9999) return 4'b0000;
        if (v < 10)   return 4'b1110;
        if (v < 100)  return 4'b1100;
        if (v < 1000) return 4'b1000;
        return 4'b0000;
    endfunction

    // Entered at a negedge; leaves at the negedge right after the expected LOAD edge.
    task automatic run_conv(input int v, input logic [3:0] dp, input bit hold);
        logic [15:0] h0;
        logic [3:0]  l0, p0;
        h0 = hexs; l0 = les; p0 = points;
        start = 1'b1; bin = 14'(v); dp_sel = dp;
        @(posedge clk);
        done_at = -1; done_cnt = 0; busy_cnt = 0; early_change = 0;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            if (c == 0) begin
                dp_sel = 4'($urandom);
                if (hold) bin = 14'd555;
                else begin
                    bin   = 14'($urandom);
                    start = 1'b0;
                end
            end
            if (hold && c == 14) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c < 15 && (hexs !== h0 || les !== l0 || points !== p0)) early_change++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bin = '0; dp_sel = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else n_pass++;
        n_checks++; if (hexs !== 16'h0000) $display("FAIL reset_hexs got %h want 0000", hexs); else n_pass++;
        n_checks++; if (points !== 4'b0000) $display("FAIL reset_points got %b want 0000", points); else n_pass++;
        n_checks++; if (les !== 4'b1110) $display("FAIL reset_les got %b want 1110", les); else n_pass++;
        n_checks++; if (les_nb !== 4'b0000) $display("FAIL reset_les_nb got %b want 0000", les_nb); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_conv(1234, 4'b0100, 1'b0);
        n_checks++; if (done_at !== 15) $display("FAIL basic_latency got %0d want 15", done_at); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL basic_done_cnt got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (busy_cnt !== 15) $display("FAIL basic_busy_cycles got %0d want 15", busy_cnt); else n_pass++;
        n_checks++; if (early_change !== 0) $display("FAIL basic_stable got %0d changes want 0", early_change); else n_pass++;
        n_checks++; if (hexs !== 16'h1234) $display("FAIL basic_hexs got %h want 1234", hexs); else n_pass++;
        n_checks++; if (les !== 4'b0000) $display("FAIL basic_les got %b want 0000", les); else n_pass++;
        n_checks++; if (points !== 4'b0100) $display("FAIL basic_points got %b want 0100", points); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL basic_ovf got %b want 0", overflow); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL basic_done_width got %b want 0", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_blanking;
        int vals[3] = '{7, 0, 50};
        foreach (vals[i]) begin
            run_conv(vals[i], 4'b0001, 1'b0);
            n_checks++; if (hexs !== model_hexs(vals[i])) $display("FAIL blank_hexs v=%0d got %h want %h", vals[i], hexs, model_hexs(vals[i])); else n_pass++;
            n_checks++; if (les !== model_les(vals[i])) $display("FAIL blank_les v=%0d got %b want %b", vals[i], les, model_les(vals[i])); else n_pass++;
            n_checks++; if (hexs_nb !== model_hexs(vals[i])) $display("FAIL noblank_hexs v=%0d got %h want %h", vals[i], hexs_nb, model_hexs(vals[i])); else n_pass++;
            n_checks++; if (les_nb !== 4'b0000) $display("FAIL noblank_les v=%0d got %b want 0000", vals[i], les_nb); else n_pass++;
        end
    endtask

    task automatic test_boundary;
        int vals[4] = '{9999, 10000, 16383, 9999};
        foreach (vals[i]) begin
            run_conv(vals[i], 4'b1000, 1'b0);
            n_checks++; if (hexs !== model_hexs(vals[i])) $display("FAIL bound_hexs v=%0d got %h want %h", vals[i], hexs, model_hexs(vals[i])); else n_pass++;
            n_checks++; if (les !== model_les(vals[i])) $display("FAIL bound_les v=%0d got %b want %b", vals[i], les, model_les(vals[i])); else n_pass++;
            n_checks++; if (overflow !== (vals[i] > 9999)) $display("FAIL bound_ovf v=%0d got %b want %b", vals[i], overflow, vals[i] > 9999); else n_pass++;
            n_checks++; if (done_at !== 15) $display("FAIL bound_latency v=%0d got %0d want 15", vals[i], done_at); else n_pass++;
        end
    endtask

    task automatic test_hold_start;
        run_conv(42, 4'b1010, 1'b1);
        n_checks++; if (done_cnt !== 1) $display("FAIL hold_done_cnt got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (hexs !== 16'h0042) $display("FAIL hold_hexs got %h want 0042", hexs); else n_pass++;
        n_checks++; if (les !== 4'b1100) $display("FAIL hold_les got %b want 1100", les); else n_pass++;
        n_checks++; if (points !== 4'b1010) $display("FAIL hold_points got %b want 1010", points); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL hold_requeued got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int spurious = 0;
        start = 1'b1; bin = 14'd321; dp_sel = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (hexs !== 16'h0000) $display("FAIL mid_hexs got %h want 0000", hexs); else n_pass++;
        n_checks++; if (les !== 4'b1110) $display("FAIL mid_les got %b want 1110", les); else n_pass++;
        n_checks++; if (points !== 4'b0000) $display("FAIL mid_points got %b want 0000", points); else n_pass++;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) spurious++;
            @(negedge clk);
        end
        n_checks++; if (spurious !== 0) $display("FAIL mid_no_done got %0d active cycles want 0", spurious); else n_pass++;
        run_conv(88, 4'b0000, 1'b0);
        n_checks++; if (hexs !== 16'h0088) $display("FAIL mid_restart_hexs got %h want 0088", hexs); else n_pass++;
        n_checks++; if (done_at !== 15) $display("FAIL mid_restart_latency got %0d want 15", done_at); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int v;
        logic [3:0] dp;
        for (int i = 0; i < 24; i++) begin
            v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
            if (i % 6 == 5) v = int'($urandom_range(0, 9));
            dp = 4'($urandom);
            run_conv(v, dp, 1'b0);
            n_checks++; if (hexs !== model_hexs(v)) $display("FAIL rand_hexs v=%0d got %h want %h", v, hexs, model_hexs(v)); else n_pass++;
            n_checks++; if (les !== model_les(v)) $display("FAIL rand_les v=%0d got %b want %b", v, les, model_les(v)); else n_pass++;
            n_checks++; if (overflow !== (v > 9999)) $display("FAIL rand_ovf v=%0d got %b want %b", v, overflow, v > 9999); else n_pass++;
            n_checks++; if (points !== dp) $display("FAIL rand_points v=%0d got %b want %b", v, points, dp); else n_pass++;
            n_checks++; if (done_at !== 15 || done_cnt !== 1) $display("FAIL rand_done v=%0d got at=%0d cnt=%0d want at=15 cnt=1", v, done_at, done_cnt); else n_pass++;
            n_checks++; if (busy_cnt !== 15) $display("FAIL rand_busy v=%0d got %0d want 15", v, busy_cnt); else n_pass++;
            n_checks++; if (hexs_nb !== model_hexs(v) || les_nb !== 4'b0000) $display("FAIL rand_noblank v=%0d got %h/%b want %h/0000", v, hexs_nb, les_nb, model_hexs(v)); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (both_high !== 0) $display("FAIL busy_done_overlap got %0d cycles want 0", both_high); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_boundary();
        test_hold_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
